// File: rtl/cbs_tx_scheduler_pkg.sv
// Shared defaults and FSM encoding for the credit-based shaper
// and its per-class credit counters.
package cbs_tx_scheduler_pkg;
  localparam int NUM_CLASSES_DEF = 8;
  localparam int CREDIT_W_DEF    = 24;
  localparam int SLOPE_W_DEF     = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;
endpackage

// File: rtl/cbs_tx_scheduler_credit_counter.sv
// Per-class signed credit with idle/send slopes,
// saturating arithmetic and negative-to-zero clamping.
module cbs_credit_counter
  import cbs_tx_scheduler_pkg::*;
#(
  parameter int CREDIT_W = CREDIT_W_DEF,
  parameter int SLOPE_W  = SLOPE_W_DEF
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable,
  input  logic                       sending_beat,
  input  logic                       granted,
  input  logic                       pending,
  input  logic [SLOPE_W-1:0]         idle_slope,
  input  logic [SLOPE_W-1:0]         send_slope,
  output logic signed [CREDIT_W-1:0] credit
);
  localparam int XW = CREDIT_W + 1;
  localparam logic signed [XW-1:0] MAXV =
    {2'b00, {(CREDIT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV =
    {2'b11, {(CREDIT_W-1){1'b0}}};

  logic signed [XW-1:0] cur;
  logic signed [XW-1:0] idle_x;
  logic signed [XW-1:0] send_x;
  logic signed [XW-1:0] inc;
  logic signed [XW-1:0] dec;
  logic signed [XW-1:0] nxt;
  logic signed [XW-1:0] sat;

  assign cur    = {credit[CREDIT_W-1], credit};
  assign idle_x = {{(XW-SLOPE_W){1'b0}}, idle_slope};
  assign send_x = {{(XW-SLOPE_W){1'b0}}, send_slope};
  assign inc    = cur + idle_x;
  assign dec    = cur - send_x;

  always_comb begin
    nxt = cur;
    if (!enable) begin
      nxt = '0;
    end else if (granted) begin
      nxt = sending_beat ? dec : cur;
    end else if (pending) begin
      nxt = inc;
    end else if (cur < 0) begin
      // recovering without a queue never builds positive credit
      nxt = (inc > 0) ? '0 : inc;
    end else begin
      nxt = '0;
    end
  end

  always_comb begin
    sat = nxt;
    if (nxt > MAXV) sat = MAXV;
    else if (nxt < MINV) sat = MINV;
  end

  always_ff @(posedge clk) begin
    if (!rstn) credit <= '0;
    else       credit <= sat[CREDIT_W-1:0];
  end
endmodule

// File: rtl/cbs_tx_scheduler.sv
// Credit-based shaper merging NUM_CLASSES byte streams into one
// egress stream; highest eligible class wins, frames never preempted.
module cbs_tx_scheduler
  import cbs_tx_scheduler_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int CREDIT_W    = CREDIT_W_DEF,
  parameter int SLOPE_W     = SLOPE_W_DEF
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_CLASSES-1:0]          cbs_enable,
  input  logic [NUM_CLASSES*SLOPE_W-1:0]  idle_slope,
  input  logic [NUM_CLASSES*SLOPE_W-1:0]  send_slope,
  input  logic [NUM_CLASSES*8-1:0]        s_axis_tdata,
  input  logic [NUM_CLASSES-1:0]          s_axis_tvalid,
  output logic [NUM_CLASSES-1:0]          s_axis_tready,
  input  logic [NUM_CLASSES-1:0]          s_axis_tlast,
  input  logic [NUM_CLASSES*2-1:0]        s_axis_tuser,
  output logic [7:0]                      m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [1:0]                      m_axis_tuser,
  output logic [2:0]                      m_axis_tdest,
  output logic [NUM_CLASSES*CREDIT_W-1:0] credit_mon
);
  localparam int GW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  state_t                      state;
  state_t                      state_nxt;
  logic [GW-1:0]               g;
  logic [GW-1:0]               g_nxt;
  logic [GW-1:0]               win;
  logic [NUM_CLASSES-1:0]      elig;
  logic                        any_elig;
  logic                        sending;
  logic                        beat;
  logic signed [CREDIT_W-1:0]  credit [NUM_CLASSES];

  assign sending  = (state == ST_SEND);
  assign any_elig = |elig;

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (elig[i]) win = GW'(i);
    end
  end

  assign m_axis_tvalid = sending & s_axis_tvalid[g];
  assign m_axis_tlast  = sending & s_axis_tlast[g];
  assign m_axis_tdata  = s_axis_tdata[{g, 3'b000} +: 8];
  assign m_axis_tuser  = s_axis_tuser[{g, 1'b0} +: 2];
  assign m_axis_tdest  = 3'(g);
  assign beat          = m_axis_tvalid & m_axis_tready;

  always_comb begin
    s_axis_tready = '0;
    if (sending) s_axis_tready[g] = m_axis_tready;
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    unique case (state)
      ST_IDLE: begin
        if (any_elig) begin
          state_nxt = ST_SEND;
          g_nxt     = win;
        end
      end
      ST_SEND: begin
        if (beat && m_axis_tlast) state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      g     <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
    end
  end

  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cls
    logic is_g;
    logic granted;

    assign elig[i] = s_axis_tvalid[i]
                   & (~cbs_enable[i] | ~credit[i][CREDIT_W-1]);
    assign is_g    = (g == GW'(i));
    // the arbitration winner is not waiting behind another class
    assign granted = (sending & is_g)
                   | (~sending & any_elig & (win == GW'(i)));

    cbs_credit_counter #(
      .CREDIT_W (CREDIT_W),
      .SLOPE_W  (SLOPE_W)
    ) u_cc (
      .clk          (clk),
      .rstn         (rstn),
      .enable       (cbs_enable[i]),
      .sending_beat (beat & sending & is_g),
      .granted      (granted),
      .pending      (s_axis_tvalid[i]),
      .idle_slope   (idle_slope[SLOPE_W*i +: SLOPE_W]),
      .send_slope   (send_slope[SLOPE_W*i +: SLOPE_W]),
      .credit       (credit[i])
    );

    assign credit_mon[CREDIT_W*i +: CREDIT_W] = credit[i];
  end
endmodule
